// File: rtl/l1_cache_ctrl.sv
// l1_cache_ctrl: tag/state controller for one set-associative L1 cache.
// Holds no data array. It tracks tag, valid, dirty and true-LRU ages per way.
// It is write-back / write-allocate, moves whole lines to and from L2, and
// keeps saturating hit/miss counters.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready  request handshake; req_op 0=read 1=write 2=flush 3=evict
//   req_addr             request byte address
//   resp_valid/resp_hit  one-cycle completion pulse and its hit flag
//   l2_req_valid/we/addr L2 line transaction (we=1 write-back, we=0 fill)
//   l2_ack               L2 completes the pending transaction
//   hit_count/miss_count saturating read/write statistics
//   busy                 controller is not idle
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE. An L2 transaction is held stable while
// l2_req_valid is high and completes on the edge where l2_ack is high. The ack
// may arrive in the first cycle. l2_ack is ignored while l2_req_valid is low.
// resp_valid has no back-pressure.
module l1_cache_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 14,
  parameter int OFFSET_WIDTH = 6,
  parameter int WAYS         = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic                  l2_req_valid,
  output logic                  l2_req_we,
  output logic [ADDR_WIDTH-1:0] l2_req_addr,
  input  logic                  l2_ack,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count,
  output logic                  busy
);
  localparam int SETS      = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int AGE_W     = $clog2(WAYS);

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_FLUSH = 2'd2;
  localparam logic [1:0] OP_EVICT = 2'd3;

  typedef enum logic [2:0] {
    S_FLUSH, S_IDLE, S_LOOKUP, S_WB, S_FILL, S_INV, S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [TAG_WIDTH-1:0]   tag_q;
  logic [INDEX_WIDTH-1:0] set_q;
  logic [1:0]             op_q;
  logic [AGE_W-1:0]       way_q;        // victim on a miss, matched way on a hit
  logic                   hit_q;
  logic [INDEX_WIDTH-1:0] flush_idx_q;
  logic                   flush_resp_q; // flush came from a request, not from reset

  logic [TAG_WIDTH-1:0] tag_mem   [SETS][WAYS];
  logic [AGE_W-1:0]     age_mem   [SETS][WAYS];
  logic [WAYS-1:0]      valid_mem [SETS];
  logic [WAYS-1:0]      dirty_mem [SETS];

  // Offset bits do not matter to a line-granular controller.
  logic unused_offset;
  assign unused_offset = ^req_addr[OFFSET_WIDTH-1:0];

  // Tag match, and victim choice: the lowest invalid way, else the oldest way.
  logic             hit_any, inv_any;
  logic [AGE_W-1:0] hit_way, inv_way, lru_way, victim_way;
  always_comb begin
    hit_any = 1'b0;
    inv_any = 1'b0;
    hit_way = '0;
    inv_way = '0;
    lru_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_mem[set_q][w] && tag_mem[set_q][w] == tag_q) begin
        hit_any = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (!valid_mem[set_q][w]) begin
        inv_any = 1'b1;
        inv_way = AGE_W'(w);
      end
      if (age_mem[set_q][w] == AGE_W'(WAYS - 1)) lru_way = AGE_W'(w);
    end
    victim_way = inv_any ? inv_way : lru_way;
  end

  logic victim_dirty, hit_dirty;
  assign victim_dirty = valid_mem[set_q][victim_way] && dirty_mem[set_q][victim_way];
  assign hit_dirty    = dirty_mem[set_q][hit_way];

  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_hit     = 1'b0;
    l2_req_valid = 1'b0;
    l2_req_we    = 1'b0;
    l2_req_addr  = '0;
    case (state_q)
      S_FLUSH: begin
        if (flush_idx_q == '1) begin
          state_d    = S_IDLE;
          resp_valid = flush_resp_q;
        end
      end
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = (req_op == OP_FLUSH) ? S_FLUSH : S_LOOKUP;
      end
      S_LOOKUP: begin
        if (op_q == OP_EVICT) state_d = (hit_any && hit_dirty) ? S_WB : S_RESP;
        else if (hit_any)     state_d = S_RESP;
        else                  state_d = victim_dirty ? S_WB : S_FILL;
      end
      S_WB: begin
        l2_req_valid = 1'b1;
        l2_req_we    = 1'b1;
        l2_req_addr  = {tag_mem[set_q][way_q], set_q, {OFFSET_WIDTH{1'b0}}};
        if (l2_ack) state_d = (op_q == OP_EVICT) ? S_INV : S_FILL;
      end
      S_FILL: begin
        l2_req_valid = 1'b1;
        l2_req_addr  = {tag_q, set_q, {OFFSET_WIDTH{1'b0}}};
        if (l2_ack) state_d = S_RESP;
      end
      S_INV:   state_d = S_RESP;
      S_RESP: begin
        resp_valid = 1'b1;
        resp_hit   = hit_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FLUSH;
      flush_idx_q  <= '0;
      flush_resp_q <= 1'b0;
      tag_q        <= '0;
      set_q        <= '0;
      op_q         <= OP_READ;
      way_q        <= '0;
      hit_q        <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FLUSH) begin
        flush_idx_q <= flush_idx_q + 1'b1;  // wraps to 0 on exit
        if (flush_idx_q == '1) flush_resp_q <= 1'b0;
      end
      if (state_q == S_IDLE && req_valid) begin
        op_q  <= req_op;
        tag_q <= req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
        set_q <= req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
        if (req_op == OP_FLUSH) begin
          flush_idx_q  <= '0;
          flush_resp_q <= 1'b1;
          hit_count    <= '0;
          miss_count   <= '0;
        end
      end
      if (state_q == S_LOOKUP) begin
        hit_q <= hit_any;
        way_q <= hit_any ? hit_way : victim_way;
        if (op_q == OP_READ || op_q == OP_WRITE) begin
          if (hit_any) begin
            if (hit_count != '1) hit_count <= hit_count + 1'b1;
          end else begin
            if (miss_count != '1) miss_count <= miss_count + 1'b1;
          end
        end
      end
    end
  end

  // The tag/state arrays need no reset: the reset-entered flush sweeps them.
  logic             upd_en;
  logic [AGE_W-1:0] upd_way;
  assign upd_en  = (state_q == S_LOOKUP && !op_q[1] && hit_any) ||
                   (state_q == S_FILL && l2_ack);
  assign upd_way = (state_q == S_FILL) ? way_q : hit_way;

  always_ff @(posedge clk) begin
    if (state_q == S_FLUSH) begin
      valid_mem[flush_idx_q] <= '0;
      dirty_mem[flush_idx_q] <= '0;
      for (int w = 0; w < WAYS; w++) begin
        tag_mem[flush_idx_q][w] <= '0;
        age_mem[flush_idx_q][w] <= AGE_W'(w);
      end
    end
    if (upd_en) begin
      // Promote upd_way to MRU; only the younger ways age, so the set stays a permutation.
      for (int w = 0; w < WAYS; w++)
        if (age_mem[set_q][w] < age_mem[set_q][upd_way])
          age_mem[set_q][w] <= age_mem[set_q][w] + 1'b1;
      age_mem[set_q][upd_way] <= '0;
    end
    if (state_q == S_LOOKUP && op_q == OP_WRITE && hit_any)
      dirty_mem[set_q][hit_way] <= 1'b1;
    if (state_q == S_FILL && l2_ack) begin
      tag_mem[set_q][way_q]   <= tag_q;
      valid_mem[set_q][way_q] <= 1'b1;
      dirty_mem[set_q][way_q] <= (op_q == OP_WRITE);
    end
    // Clean evict hit invalidates immediately; dirty evict does so after its write-back.
    if ((state_q == S_LOOKUP && op_q == OP_EVICT && hit_any && !hit_dirty) ||
        state_q == S_INV) begin
      valid_mem[set_q][(state_q == S_INV) ? way_q : hit_way] <= 1'b0;
      dirty_mem[set_q][(state_q == S_INV) ? way_q : hit_way] <= 1'b0;
      tag_mem[set_q][(state_q == S_INV) ? way_q : hit_way]   <= '0;
    end
  end
endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Bench for l1_cache_ctrl with 4 sets and 4 ways. Line addresses select the set
// with bits [7:6]. A table of directed requests holds hand-computed hit flags,
// latencies and L2 traffic. Hand-written sequences cover reset, flush and a
// reset during a write-back.
module tb_l1_cache_ctrl;
  localparam int AW = 32;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'd0;
  logic [AW-1:0] req_addr = '0;
  logic          resp_valid, resp_hit;
  logic          l2_req_valid, l2_req_we;
  logic [AW-1:0] l2_req_addr;
  logic          l2_ack = 1'b0;
  logic [CW-1:0] hit_count, miss_count;
  logic          busy;

  l1_cache_ctrl #(
    .ADDR_WIDTH(AW), .INDEX_WIDTH(2), .OFFSET_WIDTH(6), .WAYS(4), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_hit(resp_hit),
    .l2_req_valid(l2_req_valid), .l2_req_we(l2_req_we), .l2_req_addr(l2_req_addr),
    .l2_ack(l2_ack), .hit_count(hit_count), .miss_count(miss_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int tally_hit = 0;
  int tally_miss = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    int          ack_dly;
    logic        exp_hit;
    int          exp_lat;
    int          exp_nl2;
    logic        exp_we0;
    logic [31:0] exp_a0;
    logic        exp_we1;
    logic [31:0] exp_a1;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic release_reset(output int zeros, output int resp_seen);
    zeros = 0;
    resp_seen = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (resp_valid) resp_seen++;
      if (req_ready) break;
      zeros++;
      @(negedge clk);
    end
  endtask

  // Returns at the negedge of the first cycle after acceptance.
  task automatic send_req(input logic [1:0] op, input logic [31:0] addr);
    int guard = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Serves L2 with ack_dly wait cycles per transaction until resp_valid.
  task automatic run_txn(input int ack_dly, output int lat, output logic hit,
                         output int n_l2, output logic we_o[2], output logic [31:0] a_o[2]);
    int   cyc = 1;
    int   wait_cnt = 0;
    logic prev_v = 1'b0;
    logic prev_ack = 1'b0;
    bit   done = 0;
    lat = 0;
    hit = 1'b0;
    n_l2 = 0;
    we_o[0] = 1'b0; we_o[1] = 1'b0;
    a_o[0] = '0;    a_o[1] = '0;
    while (!done && cyc < 60) begin
      l2_ack = 1'b0;
      if (l2_req_valid) begin
        if (!prev_v || prev_ack) begin
          if (n_l2 < 2) begin
            we_o[n_l2] = l2_req_we;
            a_o[n_l2]  = l2_req_addr;
          end
          n_l2++;
          wait_cnt = 0;
        end
        if (wait_cnt == ack_dly) l2_ack = 1'b1;
        wait_cnt++;
      end
      prev_v   = l2_req_valid;
      prev_ack = l2_ack;
      if (resp_valid) begin
        hit  = resp_hit;
        lat  = cyc;
        done = 1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    l2_ack = 1'b0;
  endtask

  task automatic apply_vec(input int i);
    int          lat, n_l2;
    logic        hit;
    logic        we_o[2];
    logic [31:0] a_o[2];
    vec_t v;
    v = vecs[i];
    send_req(v.op, v.addr);
    run_txn(v.ack_dly, lat, hit, n_l2, we_o, a_o);
    check($sformatf("v%0d_latency", i), 64'(lat), 64'(v.exp_lat));
    check($sformatf("v%0d_hit", i), {63'd0, hit}, {63'd0, v.exp_hit});
    check($sformatf("v%0d_l2_count", i), 64'(n_l2), 64'(v.exp_nl2));
    if (v.exp_nl2 > 0) begin
      check($sformatf("v%0d_l2_we0", i), {63'd0, we_o[0]}, {63'd0, v.exp_we0});
      check($sformatf("v%0d_l2_addr0", i), 64'(a_o[0]), 64'(v.exp_a0));
    end
    if (v.exp_nl2 > 1) begin
      check($sformatf("v%0d_l2_we1", i), {63'd0, we_o[1]}, {63'd0, v.exp_we1});
      check($sformatf("v%0d_l2_addr1", i), 64'(a_o[1]), 64'(v.exp_a1));
    end
    if (v.op < 2) begin
      if (v.exp_hit) tally_hit++;
      else           tally_miss++;
    end
  endtask

  task automatic check_counts(input string tag);
    #1;
    check({tag, "_hit_count"}, 64'(hit_count), 64'(tally_hit));
    check({tag, "_miss_count"}, 64'(miss_count), 64'(tally_miss));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int zeros, resp_seen, busy_cnt, resp_at;
    logic resp_h;

    //            op    addr          dly hit lat nl2 we0  a0            we1  a1
    vecs[0]  = '{2'd0, 32'h0000_0040, 1, 0, 4, 1, 1'b0, 32'h0000_0040, 1'b0, 32'h0};
    vecs[1]  = '{2'd0, 32'h0000_0044, 1, 1, 2, 0, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[2]  = '{2'd1, 32'h0000_1000, 0, 0, 3, 1, 1'b0, 32'h0000_1000, 1'b0, 32'h0};
    vecs[3]  = '{2'd1, 32'h0000_2000, 0, 0, 3, 1, 1'b0, 32'h0000_2000, 1'b0, 32'h0};
    vecs[4]  = '{2'd1, 32'h0000_3000, 2, 0, 5, 1, 1'b0, 32'h0000_3000, 1'b0, 32'h0};
    vecs[5]  = '{2'd1, 32'h0000_4000, 0, 0, 3, 1, 1'b0, 32'h0000_4000, 1'b0, 32'h0};
    vecs[6]  = '{2'd0, 32'h0000_1008, 0, 1, 2, 0, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[7]  = '{2'd0, 32'h0000_5000, 1, 0, 6, 2, 1'b1, 32'h0000_2000, 1'b0, 32'h0000_5000};
    vecs[8]  = '{2'd0, 32'h0000_0040, 0, 0, 3, 1, 1'b0, 32'h0000_0040, 1'b0, 32'h0};
    vecs[9]  = '{2'd1, 32'h0010_0000, 0, 0, 4, 2, 1'b1, 32'h0000_3000, 1'b0, 32'h0010_0000};
    vecs[10] = '{2'd3, 32'h0010_0000, 1, 1, 5, 1, 1'b1, 32'h0010_0000, 1'b0, 32'h0};
    vecs[11] = '{2'd0, 32'h0010_0000, 0, 0, 3, 1, 1'b0, 32'h0010_0000, 1'b0, 32'h0};
    vecs[12] = '{2'd3, 32'h0010_0000, 0, 1, 2, 0, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[13] = '{2'd3, 32'h0BAD_0000, 0, 0, 2, 0, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[14] = '{2'd1, 32'h0000_7000, 0, 0, 3, 1, 1'b0, 32'h0000_7000, 1'b0, 32'h0};
    vecs[15] = '{2'd0, 32'h0000_4000, 0, 0, 3, 1, 1'b0, 32'h0000_4000, 1'b0, 32'h0};
    vecs[16] = '{2'd0, 32'h0000_4010, 0, 1, 2, 0, 1'b0, 32'h0,         1'b0, 32'h0};

    // Reset state, then the reset flush: 4 cycles without ready and no response.
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_hit", {63'd0, resp_hit}, 64'd0);
    check("rst_l2_valid", {63'd0, l2_req_valid}, 64'd0);
    check("rst_l2_we", {63'd0, l2_req_we}, 64'd0);
    check("rst_l2_addr", 64'(l2_req_addr), 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd1);
    check("rst_hit_count", 64'(hit_count), 64'd0);
    check("rst_miss_count", 64'(miss_count), 64'd0);
    release_reset(zeros, resp_seen);
    check("rst_flush_cycles", 64'(zeros), 64'd4);
    check("rst_flush_no_resp", 64'(resp_seen), 64'd0);
    check("idle_busy", {63'd0, busy}, 64'd0);

    // Fill, then a same-line hit.
    for (int i = 0; i < 2; i++) apply_vec(i);
    check_counts("after_first_reads");

    // Flush op: 4 busy cycles, response in the last of them, counters cleared.
    send_req(2'd2, 32'h0);
    busy_cnt = 0;
    resp_at = 0;
    resp_h = 1'b1;
    for (int c = 1; c < 20; c++) begin
      if (busy) busy_cnt++;
      if (resp_valid) begin
        resp_at = c;
        resp_h  = resp_hit;
      end
      if (!busy) break;
      @(negedge clk);
    end
    check("flush_busy_cycles", 64'(busy_cnt), 64'd4);
    check("flush_resp_cycle", 64'(resp_at), 64'd4);
    check("flush_resp_hit", {63'd0, resp_h}, 64'd0);
    tally_hit = 0;
    tally_miss = 0;
    check_counts("after_flush");

    // Fill all four ways of set 0, touch A, then E evicts the LRU way (B, dirty).
    for (int i = 2; i < 8; i++) apply_vec(i);
    check_counts("after_lru");
    // The flush left set 1 invalid; then write/evict corner cases in set 0.
    for (int i = 8; i < 15; i++) apply_vec(i);
    check_counts("after_evicts");

    // Reset during a write-back: D (dirty, way 3) is the LRU victim of 0x8000.
    send_req(2'd0, 32'h0000_8000);
    @(negedge clk);
    check("midwb_l2_valid", {63'd0, l2_req_valid}, 64'd1);
    check("midwb_l2_we", {63'd0, l2_req_we}, 64'd1);
    check("midwb_l2_addr", 64'(l2_req_addr), 64'h0000_4000);
    #1;
    rst_n = 1'b0;
    #1;
    check("midwb_rst_l2_valid", {63'd0, l2_req_valid}, 64'd0);
    check("midwb_rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("midwb_rst_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    release_reset(zeros, resp_seen);
    check("midwb_flush_cycles", 64'(zeros), 64'd4);
    check("midwb_no_resp", 64'(resp_seen), 64'd0);
    tally_hit = 0;
    tally_miss = 0;
    check_counts("after_midwb_reset");
    for (int i = 15; i < 17; i++) apply_vec(i);
    check_counts("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
